// File: rtl/bcd_to_bin_seq_pkg.sv
// bcd_conv_pkg: shared state type, digit limit and sizing helpers for BCD-to-binary conversion.
package bcd_conv_pkg;
  typedef enum logic [1:0] {IDLE, CONV, HOLD, DONE} state_t;
  localparam logic [3:0] BCD_MAX_DIGIT = 4'd9;
  function automatic int clog2(input longint v);
    int r;
    longint p;
    r = 0;
    p = 1;
    while (p < v) begin
      p = p << 1;
      r++;
    end
    return r;
  endfunction
  // ceil(ndig * log2(10)) in fixed point, log2(10) ~= 3.321929
  function automatic int bin_width(input int ndig);
    longint n;
    n = longint'(ndig);
    return int'((n * longint'(3321929) + longint'(999999)) / longint'(1000000));
  endfunction
endpackage

// File: rtl/bcd_to_bin_seq_if.sv
// bcd_to_bin_seq_if: BCD word input and binary result output handshake bundle.
interface bcd_to_bin_seq_if #(
  parameter int NDIG  = 10,
  parameter int OUT_W = 34,
  parameter int POS_W = 4
);
  logic in_valid, in_ready, out_valid, out_ready, out_err;
  logic [4*NDIG-1:0] bcd_in;
  logic [OUT_W-1:0] bin_out;
  logic [POS_W-1:0] err_pos;
  modport master (output in_valid, bcd_in, out_ready, input in_ready, out_valid, bin_out, out_err, err_pos);
  modport slave (input in_valid, bcd_in, out_ready, output in_ready, out_valid, bin_out, out_err, err_pos);
endinterface

// File: rtl/bcd_to_bin_seq_mac10.sv
// bcd_mac10: one decimal fold step acc*10 + digit, plus digit-invalid flag.
module bcd_mac10 import bcd_conv_pkg::*; #(
  parameter int OUT_W = 34
) (
  input  logic [OUT_W-1:0] acc,
  input  logic [3:0]       digit,
  output logic [OUT_W-1:0] acc_next,
  output logic             bad
);
  assign acc_next = (acc << 3) + (acc << 1) + OUT_W'(digit);
  assign bad = digit > BCD_MAX_DIGIT;
endmodule

// File: rtl/bcd_to_bin_seq.sv
// bcd_to_bin_seq: sequential NDIG-digit BCD-to-binary converter with a per-run conversion budget.
module bcd_to_bin_seq import bcd_conv_pkg::*; #(
  parameter int NDIG        = 10,
  parameter int OUT_W       = 34,
  parameter int MAX_SAMPLES = 300,
  parameter int CNT_W       = clog2(MAX_SAMPLES + 1),
  parameter int POS_W       = NDIG > 1 ? clog2(NDIG) : 1
) (
  input  logic             clk,
  input  logic             rnot,
  input  logic             clear,
  bcd_to_bin_seq_if.slave  bus,
  output logic [CNT_W-1:0] sample_cnt,
  output logic             budget_done
);
  if (OUT_W < bin_width(NDIG)) begin : g_width_check
    $error("OUT_W too narrow for NDIG digits");
  end
  state_t state, state_nxt;
  logic [4*NDIG-1:0] sr;
  logic [OUT_W-1:0] acc, acc_nxt;
  logic [POS_W-1:0] pos, dcnt;
  logic [CNT_W-1:0] cnt_inc;
  logic err, bad, take, give, last, hold;
  bcd_mac10 #(.OUT_W(OUT_W)) u_mac (
    .acc     (acc),
    .digit   (sr[4*NDIG-1 -: 4]),
    .acc_next(acc_nxt),
    .bad     (bad)
  );
  assign take    = bus.in_valid & bus.in_ready;
  assign give    = bus.out_valid & bus.out_ready;
  assign last    = dcnt == POS_W'(NDIG - 1);
  assign cnt_inc = sample_cnt == CNT_W'(MAX_SAMPLES) ? sample_cnt : sample_cnt + 1'b1;
  always_ff @(posedge clk or negedge rnot)
    if (!rnot) state <= IDLE;
    else state <= state_nxt;
  // clear beats a same-cycle handoff, so a cleared budget can never land in DONE
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: state_nxt = take ? CONV : IDLE;
      CONV: state_nxt = last ? HOLD : CONV;
      HOLD: state_nxt = give ? (!clear && cnt_inc == CNT_W'(MAX_SAMPLES) ? DONE : IDLE) : HOLD;
      DONE: state_nxt = clear ? IDLE : DONE;
    endcase
  end
  always_comb begin
    hold          = state == HOLD;
    bus.in_ready  = rnot & (state == IDLE);
    bus.out_valid = hold;
    bus.bin_out   = hold & ~err ? acc : '0;
    bus.out_err   = hold & err;
    bus.err_pos   = hold & err ? pos : '0;
    budget_done   = sample_cnt == CNT_W'(MAX_SAMPLES);
  end
  always_ff @(posedge clk or negedge rnot)
    if (!rnot) begin
      sr         <= '0;
      acc        <= '0;
      err        <= 1'b0;
      pos        <= '0;
      dcnt       <= '0;
      sample_cnt <= '0;
    end else begin
      if (take) begin
        sr   <= bus.bcd_in;
        acc  <= '0;
        err  <= 1'b0;
        pos  <= '0;
        dcnt <= '0;
      end else if (state == CONV) begin
        sr  <= sr << 4;
        acc <= acc_nxt;
        if (bad && !err) begin
          err <= 1'b1;
          pos <= POS_W'(NDIG - 1) - dcnt;
        end
        if (!last) dcnt <= dcnt + 1'b1;
      end
      if (clear) sample_cnt <= '0;
      else if (give) sample_cnt <= cnt_inc;
    end
endmodule
